// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared state, grant and size encodings for the
// sram-like master-port arbiter.
package sram_like_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_t;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: one-outstanding arbiter of inst/data sram-like ports.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention.
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,

  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok
);

  arb_state_t state;
  logic       gnt;
  logic       pick;
  logic       both_pick;
  logic       sel;
  logic       g_req;
  logic       aok;
  logic       dok;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt;

  assign both_pick = ~last_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= GNT_INST;
    end else if (dok) begin
      last_gnt <= gnt;
    end
  end
`else
  assign both_pick = GNT_DATA;
`endif

  always_comb begin
    pick = GNT_INST;
    unique case (1'b1)
      data_req & inst_req:  pick = both_pick;
      data_req & ~inst_req: pick = GNT_DATA;
      default:              pick = GNT_INST;
    endcase
  end

  // Idle parks the mux on the data side; m_req is low there anyway.
  assign sel   = (state == ARB_IDLE) ? GNT_DATA : gnt;
  assign g_req = (gnt == GNT_DATA) ? data_req : inst_req;

  assign m_req   = ~rst & (state == ARB_ADDR) & g_req;
  assign m_wr    = (sel == GNT_DATA) ? data_wr    : inst_wr;
  assign m_size  = (sel == GNT_DATA) ? data_size  : inst_size;
  assign m_addr  = (sel == GNT_DATA) ? data_addr  : inst_addr;
  assign m_wdata = (sel == GNT_DATA) ? data_wdata : inst_wdata;

  assign aok = m_req & m_addr_ok;
  assign dok = ~rst & m_data_ok & ((state == ARB_DATA) | aok);

  assign inst_addr_ok = aok & (gnt == GNT_INST);
  assign data_addr_ok = aok & (gnt == GNT_DATA);
  assign inst_data_ok = dok & (gnt == GNT_INST);
  assign data_data_ok = dok & (gnt == GNT_DATA);

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      gnt   <= GNT_INST;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (inst_req | data_req) begin
            gnt   <= pick;
            state <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          // A requester withdrawing before addr_ok just frees the port.
          unique case (1'b1)
            ~g_req:                          state <= ARB_IDLE;
            g_req & m_addr_ok & m_data_ok:   state <= ARB_IDLE;
            g_req & m_addr_ok & ~m_data_ok:  state <= ARB_DATA;
            default:                         state <= ARB_ADDR;
          endcase
        end
        ARB_DATA: begin
          if (m_data_ok) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: random requesters, a random-latency slave and a
// scoreboard checking grant order, routing, timing and data pass-through.
module tb_sram_like_arbiter;
  import sram_like_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, m_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [31:0] m_addr, m_wdata, m_rdata;

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        side;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t exp_m[$];
  txn_t li[$];
  txn_t ld[$];

  int   total = 0;
  int   bad = 0;
  int   n_done = 0;
  int   last_dok = -100;
  int   req_cyc[2];
  logic last_side = 1'b0;

  int   s_fix = 0, s_a = 0, s_d = 0, s_same = 0;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C1D_8000;
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic void chk(input string name,
                              input logic [127:0] got,
                              input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, got, want, cyc);
    end
  endfunction

  function automatic txn_t mk(input logic side);
    txn_t t;
    t.side  = side;
    t.wr    = 1'($urandom_range(0, 1));
    t.size  = 2'($urandom_range(0, 2));
    t.addr  = $urandom;
    t.wdata = $urandom;
    t.rdata = rd_of(t.addr);
    return t;
  endfunction

  // slave: random or fixed addr/data latency behind the master port
  int          sph = 0, ac = 0, dc = 0;
  logic [31:0] ca = '0;
  initial begin
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    m_rdata   = '0;
    forever begin
      @(posedge clk);
      #2;
      m_addr_ok = 1'b0;
      m_data_ok = 1'b0;
      if (sph == 0 && m_req) begin
        ac  = (s_fix != 0) ? s_a : int'($urandom_range(0, 2));
        sph = 1;
      end
      if (sph == 1) begin
        if (ac == 0) begin
          m_addr_ok = 1'b1;
          ca = m_addr;
          if ((s_fix != 0) ? (s_same != 0) : ($urandom_range(0, 3) == 0)) begin
            m_data_ok = 1'b1;
            m_rdata   = rd_of(ca);
            sph = 0;
          end else begin
            dc  = (s_fix != 0) ? s_d : int'($urandom_range(0, 3));
            sph = 2;
          end
        end else begin
          ac--;
        end
      end else if (sph == 2) begin
        if (dc == 0) begin
          m_data_ok = 1'b1;
          m_rdata   = rd_of(ca);
          sph = 0;
        end else begin
          dc--;
        end
      end
    end
  end

  // monitor: pops the expected service order and checks each cycle
  txn_t cur;
  logic act = 1'b0;
  logic prev_mreq = 1'b0;
  int   want;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 1'b0;
        prev_mreq = 1'b0;
      end else begin
        if (m_req && !prev_mreq) begin
          if (act || exp_m.size() == 0) begin
            total++;
            bad++;
            $display("FAIL grant: unexpected m_req at cycle %0d", cyc);
          end else begin
            cur = exp_m.pop_front();
            act = 1'b1;
            want = req_cyc[cur.side] + 1;
            if (last_dok + 2 > want) want = last_dok + 2;
            chk("start_cycle", 128'(cyc), 128'(want));
          end
        end
        if (m_req && act) begin
          chk("m_fields", {m_wr, m_size, m_addr, m_wdata},
              {cur.wr, cur.size, cur.addr, cur.wdata});
          chk("addr_ok_route", {inst_addr_ok, data_addr_ok},
              cur.side ? {1'b0, m_addr_ok} : {m_addr_ok, 1'b0});
        end else begin
          chk("idle_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        end
        if (inst_data_ok || data_data_ok) begin
          if (!act) begin
            total++;
            bad++;
            $display("FAIL stray_data_ok: inst=%0b data=%0b at cycle %0d",
                     inst_data_ok, data_data_ok, cyc);
          end else begin
            chk("data_ok_route", {inst_data_ok, data_data_ok, m_data_ok},
                cur.side ? 3'b011 : 3'b101);
            if (!cur.wr)
              chk("rdata", cur.side ? data_rdata : inst_rdata, cur.rdata);
            act = 1'b0;
            last_dok = cyc;
            n_done++;
          end
        end
        prev_mreq = m_req;
      end
    end
  end

  task automatic put(input txn_t t);
    if (t.side) begin
      data_req = 1'b1; data_wr = t.wr; data_size = t.size;
      data_addr = t.addr; data_wdata = t.wdata;
    end else begin
      inst_req = 1'b1; inst_wr = t.wr; inst_size = t.size;
      inst_addr = t.addr; inst_wdata = t.wdata;
    end
    req_cyc[t.side] = cyc;
  endtask

  // reference order: both pending -> data (or alternate), else the one pending
  task automatic plan();
    int   i = 0, d = 0;
    logic p;
    while (i < li.size() || d < ld.size()) begin
      if (i < li.size() && d < ld.size()) begin
`ifdef ARB_ROUND_ROBIN_EN
        p = ~last_side;
`else
        p = 1'b1;
`endif
      end else begin
        p = (d < ld.size());
      end
      if (p) begin
        exp_m.push_back(ld[d]);
        d++;
      end else begin
        exp_m.push_back(li[i]);
        i++;
      end
      last_side = p;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst_req = 1'b0;
    data_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    last_side = 1'b0;
  endtask

  task automatic run_round();
    int   ni = 0, nd = 0, guard = 0, goal;
    logic hi, hd, oi, od;
    goal = n_done + li.size() + ld.size();
    plan();
    @(posedge clk);
    #1;
    if (li.size() > 0) put(li[0]);
    if (ld.size() > 0) put(ld[0]);
    while (n_done < goal && guard < 400) begin
      @(negedge clk);
      hi = inst_req & inst_addr_ok;
      hd = data_req & data_addr_ok;
      oi = inst_data_ok;
      od = data_data_ok;
      @(posedge clk);
      #1;
      guard++;
      if (hi) inst_req = 1'b0;
      if (hd) data_req = 1'b0;
      if (oi) begin
        ni++;
        if (ni < li.size()) put(li[ni]);
      end
      if (od) begin
        nd++;
        if (nd < ld.size()) put(ld[nd]);
      end
    end
    chk("round_done", 128'(n_done), 128'(goal));
    if (n_done < goal) begin
      exp_m.delete();
      do_reset();
      repeat (10) @(posedge clk);
      #1;
      n_done = goal;
    end
    li.delete();
    ld.delete();
  endtask

  txn_t t;
  int   g;
  logic hd2;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = '0;
    inst_addr = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0;
    data_addr = '0; data_wdata = '0;
    req_cyc[0] = 0;
    req_cyc[1] = 0;
    do_reset();
    @(negedge clk);
    chk("reset_outs", {m_req, inst_addr_ok, inst_data_ok,
                       data_addr_ok, data_data_ok}, 0);

    // single inst read, addr_ok after 2 cycles, data_ok 3 later
    s_fix = 1; s_a = 2; s_d = 2; s_same = 0;
    t = mk(GNT_INST);
    t.wr = 1'b0; t.size = SIZE_WORD;
    t.addr = 32'hBFC0_0000; t.rdata = rd_of(t.addr);
    li.push_back(t);
    run_round();

    // simultaneous: data word write first, then inst
    s_fix = 0;
    li.push_back(mk(GNT_INST));
    t = mk(GNT_DATA);
    t.wr = 1'b1; t.size = SIZE_WORD;
    t.addr = 32'h8000_1000; t.wdata = 32'hDEAD_BEEF;
    ld.push_back(t);
    run_round();

    // same-cycle addr_ok and data_ok on both transactions
    s_fix = 1; s_a = 0; s_same = 1;
    li.push_back(mk(GNT_INST));
    ld.push_back(mk(GNT_DATA));
    run_round();

    // byte store passes size and unaligned address unchanged
    s_fix = 0; s_same = 0;
    t = mk(GNT_DATA);
    t.wr = 1'b1; t.size = SIZE_BYTE; t.addr = 32'h8000_0003;
    ld.push_back(t);
    run_round();

    // reset while waiting for data: late m_data_ok must not escape
    s_fix = 1; s_a = 0; s_d = 6; s_same = 0;
    t = mk(GNT_DATA);
    t.wr = 1'b0;
    exp_m.push_back(t);
    @(posedge clk);
    #1;
    put(t);
    hd2 = 1'b0;
    g = 0;
    while (!hd2 && g < 50) begin
      @(negedge clk);
      hd2 = data_req & data_addr_ok;
      @(posedge clk);
      #1;
      g++;
    end
    chk("rst_test_addr_hs", 128'(hd2), 128'(1));
    data_req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_side = 1'b0;
    exp_m.delete();
    repeat (9) begin
      @(negedge clk);
      chk("rst_abort", {m_req, inst_data_ok, data_data_ok,
                        inst_addr_ok, data_addr_ok}, 0);
    end
    s_fix = 0;

    // both sides requesting continuously for 4 transactions each
    for (int i = 0; i < 4; i++) begin
      li.push_back(mk(GNT_INST));
      ld.push_back(mk(GNT_DATA));
    end
    run_round();

    // random rounds
    for (int r = 0; r < 30; r++) begin
      int a = $urandom_range(0, 3);
      int b = $urandom_range(0, 3);
      if (a + b == 0) a = 1;
      for (int i = 0; i < a; i++) li.push_back(mk(GNT_INST));
      for (int i = 0; i < b; i++) ld.push_back(mk(GNT_DATA));
      s_fix = 0;
      run_round();
    end

    chk("queue_empty", 128'(exp_m.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like master port (toward the AXI bridge) between the instruction-fetch and data-memory sram-like requesters.
- Allows one outstanding transaction at a time.
- Grant is registered and held from arbitration until the data_ok of the granted transaction.
- Data side has fixed priority; optional round-robin.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, read/write data width of all ports.

Ports:
- clk  in  1  clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- inst_req / inst_wr  in  1 / 1  instruction-side request, write flag.
- inst_size  in  2  instruction-side size (00 byte, 01 half, 10 word).
- inst_addr / inst_wdata  in  ADDR_W / DATA_W  instruction-side address, write data.
- inst_rdata  out  DATA_W  instruction-side read data.
- inst_addr_ok / inst_data_ok  out  1 / 1  instruction-side handshakes.
- data_req / data_wr  in  1 / 1  data-side request, write flag.
- data_size  in  2  data-side size.
- data_addr / data_wdata  in  ADDR_W / DATA_W  data-side address, write data.
- data_rdata  out  DATA_W  data-side read data.
- data_addr_ok / data_data_ok  out  1 / 1  data-side handshakes.
- m_req / m_wr  out  1 / 1  master request, write flag.
- m_size  out  2  master size.
- m_addr / m_wdata  out  ADDR_W / DATA_W  master address, write data.
- m_rdata  in  DATA_W  master read data.
- m_addr_ok / m_data_ok  in  1 / 1  master handshakes.

Behaviour:
- FSM states: IDLE, ADDR, DATA. Register gnt: 0 = inst, 1 = data.
- Reset (sync, rst=1): state=IDLE, gnt=0, last_gnt=0. All *_addr_ok, *_data_ok and m_req are 0 in the cycle after reset.
- Reset mid-transaction aborts to IDLE. A late m_data_ok is ignored.
- IDLE:
  - m_req=0.
  - If data_req=1, gnt<=1 and go to ADDR.
  - Else if inst_req=1, gnt<=0 and go to ADDR.
  - Else stay in IDLE.
  - Cost: one fixed arbitration cycle.
- ADDR:
  - m_req follows the granted requester's req.
  - m_wr, m_size, m_addr, m_wdata are muxed from the granted requester by gnt.
  - Granted *_addr_ok = m_addr_ok & m_req.
  - If m_addr_ok & m_data_ok in the same cycle: both oks are forwarded and the state goes to IDLE.
  - Else if m_addr_ok: go to DATA.
  - If the granted requester drops req before addr_ok (protocol violation), go to IDLE with no handshake forwarded.
- DATA:
  - m_req=0.
  - Granted *_data_ok = m_data_ok.
  - On m_data_ok, go to IDLE.
  - New requests are not accepted.
- Outputs:
  - inst_rdata = data_rdata = m_rdata, combinational pass-through, valid only with that side's data_ok.
  - The non-granted side always sees addr_ok=0 and data_ok=0.
  - In IDLE, m_addr, m_wdata, m_size and m_wr carry the data-side values; they are don't-care while m_req=0.
- Latency:
  - Minimum transaction is 1 arbitration cycle + addr handshake + data handshake.
  - Back-to-back transactions have one IDLE cycle between them.
- Simultaneous requests: resolved in IDLE only; a requester arriving during ADDR or DATA waits.
- last_gnt <= gnt on every completed data_ok.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: in IDLE, when both sides request, grant goes to the side not equal to last_gnt. Single requests are granted directly.
- Undefined: fixed data-over-instruction priority. last_gnt is not used and may be optimised away.

Decomposition:
- Shared package sram_like_pkg holds:
  - enum arb_state_t {ARB_IDLE, ARB_ADDR, ARB_DATA};
  - constants GNT_INST=1'b0 and GNT_DATA=1'b1;
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
- No sub-module is required. The grant-pick logic is small enough to stay inline.

Test Plan:
- Single inst read: inst_req=1, inst_addr=0xBFC00000; m_addr_ok 2 cycles after m_req, m_data_ok 3 cycles later with m_rdata=0x3C1D8000 -> inst_addr_ok and inst_data_ok pulse once each, inst_rdata=0x3C1D8000, data_* oks stay 0.
- Simultaneous requests: inst and data both request in IDLE; data is a word write, data_addr=0x80001000, data_wdata=0xDEADBEEF -> the data side is served first with m_wr=1 and m_size=10. Inst is served next.
- Same-cycle ok: m_addr_ok and m_data_ok asserted together -> both oks are forwarded in the same cycle, the FSM returns to IDLE, and one bubble precedes the next grant.
- Reset mid-DATA: rst=1 in DATA, then m_data_ok arrives -> no *_data_ok is forwarded, state=IDLE, m_req=0.
- Round robin (ARB_ROUND_ROBIN_EN defined): both sides request continuously for 4 transactions -> grants are data, inst, data, inst. With the macro undefined, all 4 go to data.
- Byte store: data_req with data_size=00, data_addr=0x80000003 -> m_size=00 and m_addr=0x80000003 pass through unchanged while in ADDR.
